dvp_pattern_tx: RTL and testbench

- Synthetic OV7670-style DVP camera source: drives pclk, vsync, href and an 8-bit data bus carrying RGB565 pixels as two bytes, high byte first.
- Exercises the camera capture path (capture logic, VGA frame buffer) on hardware or in simulation without a physical sensor.
- Sits in place of the camera pins; all outputs are generated in the system clk domain.

---
 rtl/dvp_pattern_tx.sv | 161 ++++++++++++++++
 tb/tb_dvp_pattern_tx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dvp_pattern_tx.sv
// dvp_pattern_tx: synthetic OV7670-style DVP RGB565 source; define DVP_PATTERN_TX_CRC_EN to get a per-frame CRC-16-CCITT on frame_crc
module dvp_pattern_tx #(
  parameter int H_ACTIVE    = 640,
  parameter int H_BLANK     = 144,
  parameter int V_ACTIVE    = 480,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10,
  parameter int CLK_DIV     = 1,
  parameter int BAR_SHIFT   = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  pattern,
  input  logic [15:0] solid_color,
  output logic        pclk,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  data,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic [15:0] frame_crc
);
  localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
  localparam int V_MAX_A  = VSYNC_LINES > V_BACK ? VSYNC_LINES : V_BACK;
  localparam int V_MAX_B  = V_ACTIVE > V_FRONT ? V_ACTIVE : V_FRONT;
  localparam int V_MAX    = V_MAX_A > V_MAX_B ? V_MAX_A : V_MAX_B;
  localparam int HW       = LINE_LEN > 1 ? $clog2(LINE_LEN) : 1;
  localparam int VW       = V_MAX > 1 ? $clog2(V_MAX) : 1;
  localparam int DW       = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                       16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic          pclk_q, pclk_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          vsync_q, vsync_d;
  logic          href_q, href_d;
  logic [7:0]    data_q, data_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [15:0]   fcount_q, fcount_d;
  logic [1:0]    pat_q, pat_d;
  logic [15:0]   solid_q, solid_d;
  logic          tick, fall, eol, last, start, hact;
  logic [31:0]   lines, col, row;
  logic [15:0]   pix;
  logic [7:0]    byte_v;

  // registers: pclk divider, frame position, latched frame settings and pin outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      div_q    <= '0;
      pclk_q   <= 1'b0;
      h_q      <= '0;
      v_q      <= '0;
      vsync_q  <= 1'b0;
      href_q   <= 1'b0;
      data_q   <= 8'h00;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fcount_q <= 16'h0000;
      pat_q    <= 2'd0;
      solid_q  <= 16'h0000;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      pclk_q   <= pclk_d;
      h_q      <= h_d;
      v_q      <= v_d;
      vsync_q  <= vsync_d;
      href_q   <= href_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      fcount_q <= fcount_d;
      pat_q    <= pat_d;
      solid_q  <= solid_d;
    end
  end

  // sequencing happens only on pclk falls; outputs decode the position being entered
  always_comb begin
    tick     = div_q == DW'(CLK_DIV - 1);
    fall     = tick && pclk_q;
    div_d    = tick ? '0 : div_q + 1'b1;
    pclk_d   = tick ? ~pclk_q : pclk_q;
    lines    = state_q == VSYNC ? 32'(VSYNC_LINES) : state_q == VBACK ? 32'(V_BACK) :
               state_q == ACTIVE ? 32'(V_ACTIVE) : 32'(V_FRONT);
    eol      = h_q == HW'(LINE_LEN - 1);
    last     = eol && 32'(v_q) == lines - 32'd1;
    start    = fall && enable && (state_q == IDLE || (state_q == VFRONT && last));
    state_d  = !fall ? state_q : start ? VSYNC : (state_q == IDLE || !last) ? state_q :
               state_q == VSYNC ? VBACK : state_q == VBACK ? ACTIVE : state_q == ACTIVE ? VFRONT : IDLE;
    h_d      = fall && state_q != IDLE ? (eol ? '0 : h_q + 1'b1) : h_q;
    v_d      = fall && state_q != IDLE && eol ? (last ? '0 : v_q + 1'b1) : v_q;
    pat_d    = start ? pattern : pat_q;
    solid_d  = start ? solid_color : solid_q;
    col      = 32'(h_d) >> 1;
    row      = 32'(v_d);
    hact     = state_d == ACTIVE && 32'(h_d) < 32'(2 * H_ACTIVE);
    pix      = pat_d == 2'd0 ? BARS[3'((col >> BAR_SHIFT) & 32'd7)] :
               pat_d == 2'd1 ? {row[4:0], col[5:0], fcount_q[4:0]} :
               pat_d == 2'd2 ? solid_d : 16'(row * 32'(H_ACTIVE) + col);
    byte_v   = h_d[0] ? pix[7:0] : pix[15:8];
    done_d   = fall && state_q == ACTIVE && 32'(v_q) == 32'(V_ACTIVE - 1) &&
               32'(h_q) == 32'(2 * H_ACTIVE - 1);
    fcount_d = fcount_q + {15'd0, done_d};
    vsync_d  = fall ? state_d == VSYNC : vsync_q;
    href_d   = fall ? hact : href_q;
    data_d   = fall ? (hact ? byte_v : 8'h00) : data_q;
    busy_d   = fall ? state_d != IDLE : busy_q;
  end

  assign pclk        = pclk_q;
  assign vsync       = vsync_q;
  assign href        = href_q;
  assign data        = data_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign frame_count = fcount_q;

`ifdef DVP_PATTERN_TX_CRC_EN
  logic [15:0] crc_q, crc_d, fcrc_q, fcrc_d;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? (r << 1) ^ 16'h1021 : r << 1;
    return r;
  endfunction

  // accumulate every href byte of the frame, publish the result on frame_done
  always_comb begin
    crc_d  = start ? 16'hFFFF : (fall && hact) ? crc_step(crc_q, byte_v) : crc_q;
    fcrc_d = done_d ? crc_q : fcrc_q;
  end

  // crc accumulator and published value
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q  <= 16'h0000;
      fcrc_q <= 16'h0000;
    end else begin
      crc_q  <= crc_d;
      fcrc_q <= fcrc_d;
    end
  end

  assign frame_crc = fcrc_q;
`else
  assign frame_crc = 16'h0000;
`endif
endmodule

// File: tb/tb_dvp_pattern_tx.sv
// tb_dvp_pattern_tx: directed frame vectors and corner sequences for dvp_pattern_tx
module tb_dvp_pattern_tx;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  pattern = 2'd0;
  logic [15:0] solid_color = 16'h0000;
  logic        pclk, vsync, href, busy, frame_done;
  logic [7:0]  data;
  logic [15:0] frame_count, frame_crc;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_rise = 0;

  typedef struct {
    logic [1:0]       pat;
    logic [15:0]      solid;
    logic             en_after;
    logic             chk_period;
    logic [15:0]      fc;
    logic [2:0][63:0] lines;
  } vec_t;

  vec_t vecs [6];

  dvp_pattern_tx #(
    .H_ACTIVE(4), .H_BLANK(2), .V_ACTIVE(3), .VSYNC_LINES(1),
    .V_BACK(1), .V_FRONT(1), .CLK_DIV(1), .BAR_SHIFT(0)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .pattern(pattern), .solid_color(solid_color),
    .pclk(pclk), .vsync(vsync), .href(href), .data(data), .busy(busy),
    .frame_done(frame_done), .frame_count(frame_count), .frame_crc(frame_crc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec_t mk(input logic [1:0] p, input logic [15:0] s, input logic ea,
                              input logic cp, input logic [15:0] fc,
                              input logic [63:0] l0, input logic [63:0] l1, input logic [63:0] l2);
    vec_t v;
    v.pat = p;
    v.solid = s;
    v.en_after = ea;
    v.chk_period = cp;
    v.fc = fc;
    v.lines[0] = l0;
    v.lines[1] = l1;
    v.lines[2] = l2;
    return v;
  endfunction

  function automatic logic [15:0] crc_model(input vec_t v);
    logic [15:0] c;
    logic [63:0] ln;
    c = 16'hFFFF;
    for (int l = 0; l < 3; l++) begin
      ln = v.lines[l];
      for (int b = 0; b < 8; b++) begin
        c = c ^ {ln[63-8*b -: 8], 8'h00};
        for (int k = 0; k < 8; k++) c = c[15] ? (c << 1) ^ 16'h1021 : c << 1;
      end
    end
    return c;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic run_frame(input int k);
    vec_t        v;
    int          to, vs_p, blank_p, nb, runs, runlen, gap, shape_bad, zero_bad, ndone, quiet_bad;
    logic        pp, ph;
    logic [63:0] got [3];
    logic [15:0] exp_crc;
    v = vecs[k];
    pattern = v.pat;
    solid_color = v.solid;
    enable = 1'b1;
    to = 0;
    do begin
      @(negedge clk);
      to++;
    end while (vsync !== 1'b1 && to < 400);
    if (vsync !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL f%0d_vsync_start timeout got=0 exp=1", k);
      return;
    end
    if (v.chk_period) chk($sformatf("f%0d_period", k), 64'(cyc - last_rise), 64'd120);
    last_rise = cyc;
    pp = pclk; ph = 1'b0;
    vs_p = 0; blank_p = 0; nb = 0; runs = 0; runlen = 0; gap = 0;
    shape_bad = 0; zero_bad = 0; ndone = 0; to = 0;
    for (int l = 0; l < 3; l++) got[l] = '0;
    while (ndone == 0 && to < 400) begin
      @(negedge clk);
      to++;
      if (frame_done === 1'b1) ndone++;
      if (href !== 1'b1 && data !== 8'h00) zero_bad++;
      if (pclk === 1'b1 && pp === 1'b0) begin
        if (vsync === 1'b1) vs_p++;
        else if (href === 1'b1) begin
          if (ph === 1'b0) begin
            if (runs > 0 && gap != 2) shape_bad++;
            runs++;
            runlen = 0;
            if (runs == 1) enable = v.en_after;
          end
          runlen++;
          if (nb < 24) got[nb/8][63-8*(nb%8) -: 8] = data;
          nb++;
        end else begin
          if (ph === 1'b1) begin
            if (runlen != 8) shape_bad++;
            gap = 0;
          end
          if (runs == 0) blank_p++;
          else gap++;
        end
        ph = href;
      end
      pp = pclk;
    end
    if (ndone == 0) begin
      checks++;
      errors++;
      $display("FAIL f%0d_frame_done timeout got=0 exp=1", k);
    end else begin
`ifdef DVP_PATTERN_TX_CRC_EN
      exp_crc = crc_model(v);
`else
      exp_crc = 16'h0000;
`endif
      chk($sformatf("f%0d_frame_count", k), 64'(frame_count), 64'(v.fc));
      chk($sformatf("f%0d_frame_crc", k), 64'(frame_crc), 64'(exp_crc));
    end
    if (runlen != 8) shape_bad++;
    repeat (20) begin
      @(negedge clk);
      if (frame_done === 1'b1) ndone++;
    end
    chk($sformatf("f%0d_vsync_periods", k), 64'(vs_p), 64'd10);
    chk($sformatf("f%0d_back_periods", k), 64'(blank_p), 64'd10);
    chk($sformatf("f%0d_bytes", k), 64'(nb), 64'd24);
    chk($sformatf("f%0d_lines", k), 64'(runs), 64'd3);
    chk($sformatf("f%0d_href_shape", k), 64'(shape_bad), 64'd0);
    chk($sformatf("f%0d_data_zero", k), 64'(zero_bad), 64'd0);
    chk($sformatf("f%0d_done_pulses", k), 64'(ndone), 64'd1);
    for (int l = 0; l < 3; l++) chk($sformatf("f%0d_line%0d", k, l), got[l], v.lines[l]);
    if (!v.en_after) begin
      repeat (30) @(negedge clk);
      chk($sformatf("f%0d_idle_busy", k), 64'(busy), 64'd0);
      quiet_bad = 0;
      repeat (200) begin
        @(negedge clk);
        if (vsync !== 1'b0 || busy !== 1'b0) quiet_bad++;
      end
      chk($sformatf("f%0d_idle_quiet", k), 64'(quiet_bad), 64'd0);
    end
  endtask

  initial begin
    int   bad_a, bad_b, to, nr;
    logic prev, ph;
    vecs[0] = mk(2'd3, 16'h0000, 1'b1, 1'b0, 16'd1,
                 64'h0000_0001_0002_0003, 64'h0004_0005_0006_0007, 64'h0008_0009_000A_000B);
    vecs[1] = mk(2'd0, 16'h0000, 1'b0, 1'b1, 16'd2,
                 64'hFFFF_FFE0_07FF_07E0, 64'hFFFF_FFE0_07FF_07E0, 64'hFFFF_FFE0_07FF_07E0);
    vecs[2] = mk(2'd2, 16'hABCD, 1'b1, 1'b0, 16'd3,
                 64'hABCD_ABCD_ABCD_ABCD, 64'hABCD_ABCD_ABCD_ABCD, 64'hABCD_ABCD_ABCD_ABCD);
    vecs[3] = mk(2'd1, 16'h0000, 1'b1, 1'b1, 16'd4,
                 64'h0003_0023_0043_0063, 64'h0803_0823_0843_0863, 64'h1003_1023_1043_1063);
    vecs[4] = mk(2'd2, 16'h0000, 1'b1, 1'b1, 16'd5, 64'h0, 64'h0, 64'h0);
    vecs[5] = mk(2'd2, 16'h0000, 1'b0, 1'b1, 16'd6, 64'h0, 64'h0, 64'h0);
    @(posedge clk);
    bad_a = 0;
    repeat (5) begin
      @(negedge clk);
      if ({pclk, vsync, href, data, busy, frame_done, frame_count, frame_crc} !== '0) bad_a++;
    end
    chk("reset_outputs", 64'(bad_a), 64'd0);
    rst = 1'b0;
    prev = pclk;
    bad_a = 0;
    bad_b = 0;
    repeat (100) begin
      @(negedge clk);
      if (pclk !== ~prev) bad_a++;
      prev = pclk;
      if ({vsync, href, data, busy, frame_done} !== '0) bad_b++;
    end
    chk("pclk_toggle", 64'(bad_a), 64'd0);
    chk("idle_quiet", 64'(bad_b), 64'd0);
    for (int k = 0; k < 6; k++) run_frame(k);
    pattern = 2'd3;
    enable = 1'b1;
    to = 0;
    do begin
      @(negedge clk);
      to++;
    end while (vsync !== 1'b1 && to < 400);
    nr = 0;
    ph = 1'b0;
    while (nr < 2 && to < 800) begin
      @(negedge clk);
      to++;
      if (href === 1'b1 && ph === 1'b0) nr++;
      ph = href;
    end
    chk("abort_reached_line1", 64'(nr), 64'd2);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_outputs", 64'({pclk, vsync, href, data, busy, frame_done}), 64'd0);
    chk("abort_frame_count", 64'(frame_count), 64'd0);
    chk("abort_frame_crc", 64'(frame_crc), 64'd0);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad_a = 0;
    repeat (200) begin
      @(negedge clk);
      if (frame_done !== 1'b0 || frame_count !== 16'h0000 || busy !== 1'b0) bad_a++;
    end
    chk("abort_no_done", 64'(bad_a), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
